// File: rtl/flushable_pipeline_regs_if.sv
// Control, flush and data bundle for flushable_pipeline_regs.
// The pipeline block connects as slave; the upstream driver connects as master.
interface flushable_pipeline_regs_if #(
  parameter int LANES         = 2,
  parameter int DEPTH         = 3,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int AL_PTR_WIDTH  = 6
);
  localparam int OCC_W = $clog2(LANES*DEPTH+1);
  localparam int FC_W  = $clog2(LANES*(DEPTH+1)+1);

  logic                             stall;
  logic                             clear;
  logic [LANES-1:0]                 inValid;
  logic [LANES*PAYLOAD_WIDTH-1:0]   inPayload;
  logic [LANES*AL_PTR_WIDTH-1:0]    inAlPtr;
  logic                             flushDetectRange;
  logic                             flushAll;
  logic [AL_PTR_WIDTH-1:0]          flushHeadPtr;
  logic [AL_PTR_WIDTH-1:0]          flushTailPtr;
  logic [LANES-1:0]                 outValid;
  logic [LANES*PAYLOAD_WIDTH-1:0]   outPayload;
  logic [LANES*AL_PTR_WIDTH-1:0]    outAlPtr;
  logic [OCC_W-1:0]                 occupancy;
  logic [FC_W-1:0]                  flushedCount;

  modport master (
    output stall, clear, inValid, inPayload, inAlPtr,
    output flushDetectRange, flushAll, flushHeadPtr, flushTailPtr,
    input  outValid, outPayload, outAlPtr, occupancy, flushedCount
  );

  modport slave (
    input  stall, clear, inValid, inPayload, inAlPtr,
    input  flushDetectRange, flushAll, flushHeadPtr, flushTailPtr,
    output outValid, outPayload, outAlPtr, occupancy, flushedCount
  );
endinterface

// File: rtl/flushable_pipeline_regs.sv
// Multi-lane, multi-stage pipeline registers with stall/clear control and
// selective kill of in-flight entries whose active-list pointer lies in a ring range.
module flushable_pipeline_regs #(
  parameter int LANES         = 2,
  parameter int DEPTH         = 3,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int AL_PTR_WIDTH  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  flushable_pipeline_regs_if.slave bus
);
  localparam int OCC_W = $clog2(LANES*DEPTH+1);
  localparam int FC_W  = $clog2(LANES*(DEPTH+1)+1);

  logic [DEPTH-1:0][LANES-1:0]                    valid_r;
  logic [DEPTH-1:0][LANES-1:0][PAYLOAD_WIDTH-1:0] payload_r;
  logic [DEPTH-1:0][LANES-1:0][AL_PTR_WIDTH-1:0]  ptr_r;
  logic [OCC_W-1:0]                               occupancy_r;
  logic [DEPTH-1:0][LANES-1:0]                    valid_nxt_s;
  logic [FC_W-1:0]                                flushed_count_s;
  logic                                           hit_s;

  // Ring-range membership; tail < head means the range wraps past the top of the ring.
  function automatic logic range_match(
    input logic                    detect,
    input logic                    all,
    input logic [AL_PTR_WIDTH-1:0] head,
    input logic [AL_PTR_WIDTH-1:0] tail,
    input logic [AL_PTR_WIDTH-1:0] p
  );
    logic m;
    if (!detect) begin
      m = 1'b0;
    end else if (all) begin
      m = 1'b1;
    end else if (tail > head) begin
      m = (p >= head) && (p < tail);
    end else if (tail < head) begin
      m = (p >= head) || (p < tail);
    end else begin
      m = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH*LANES-1:0] v);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH*LANES; i++) begin
      c = c + OCC_W'(v[i]);
    end
    return c;
  endfunction

  // Next-state valid bits and the number of live entries the flush kills this cycle.
  always_comb begin
    valid_nxt_s     = valid_r;
    flushed_count_s = '0;
    hit_s           = 1'b0;
    if (bus.clear) begin
      valid_nxt_s = '0;
    end else if (bus.stall) begin
      for (int k = 0; k < DEPTH; k++) begin
        for (int l = 0; l < LANES; l++) begin
          hit_s = valid_r[k][l] & range_match(bus.flushDetectRange, bus.flushAll,
                                              bus.flushHeadPtr, bus.flushTailPtr, ptr_r[k][l]);
          valid_nxt_s[k][l] = valid_r[k][l] & ~hit_s;
          flushed_count_s   = flushed_count_s + FC_W'(hit_s);
        end
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        hit_s = bus.inValid[l] & range_match(bus.flushDetectRange, bus.flushAll,
                                             bus.flushHeadPtr, bus.flushTailPtr,
                                             bus.inAlPtr[l*AL_PTR_WIDTH +: AL_PTR_WIDTH]);
        valid_nxt_s[0][l] = bus.inValid[l] & ~hit_s;
        flushed_count_s   = flushed_count_s + FC_W'(hit_s);
      end
      // The output stage drains this cycle, so only stages 0..DEPTH-2 feed forward.
      for (int k = 1; k < DEPTH; k++) begin
        for (int l = 0; l < LANES; l++) begin
          hit_s = valid_r[k-1][l] & range_match(bus.flushDetectRange, bus.flushAll,
                                                bus.flushHeadPtr, bus.flushTailPtr, ptr_r[k-1][l]);
          valid_nxt_s[k][l] = valid_r[k-1][l] & ~hit_s;
          flushed_count_s   = flushed_count_s + FC_W'(hit_s);
        end
      end
    end
  end

  // Stage registers; payload and pointer move only on an advance, valid follows valid_nxt_s.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r     <= '0;
      payload_r   <= '0;
      ptr_r       <= '0;
      occupancy_r <= '0;
    end else begin
      valid_r     <= valid_nxt_s;
      occupancy_r <= popcount(valid_nxt_s);
      if (!bus.clear && !bus.stall) begin
        payload_r[0] <= bus.inPayload;
        ptr_r[0]     <= bus.inAlPtr;
        for (int k = 1; k < DEPTH; k++) begin
          payload_r[k] <= payload_r[k-1];
          ptr_r[k]     <= ptr_r[k-1];
        end
      end else begin
        payload_r <= payload_r;
        ptr_r     <= ptr_r;
      end
    end
  end

  assign bus.outValid     = valid_r[DEPTH-1];
  assign bus.outPayload   = payload_r[DEPTH-1];
  assign bus.outAlPtr     = ptr_r[DEPTH-1];
  assign bus.occupancy    = occupancy_r;
  assign bus.flushedCount = flushed_count_s;
endmodule

// File: doc/flushable_pipeline_regs.md
Name: flushable_pipeline_regs

Overview:
- Parametrised multi-lane, multi-stage pipeline register block for the back-end pipelines.
- Each entry carries a valid bit, a payload and an active-list pointer.
- Honours the standard stall/clear pipeline control.
- On recovery, selectively kills in-flight entries whose active-list pointer falls inside a flush range, with ring wrap-around. This replaces hand-written per-stage flush logic in each stage.

Parameters:
- LANES, 2, number of parallel ops per stage (≥1)
- DEPTH, 3, number of register stages from input to output (≥1)
- PAYLOAD_WIDTH, 32, payload bits per lane
- AL_PTR_WIDTH, 6, active-list index width; the active list is a ring of 2^AL_PTR_WIDTH entries

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hold all stages
- clear  in  1  invalidate all stages
- inValid  in  LANES  per-lane valid of the incoming op
- inPayload  in  LANES*PAYLOAD_WIDTH  per-lane payload; lane i at bits [i*PW +: PW]
- inAlPtr  in  LANES*AL_PTR_WIDTH  per-lane active-list pointer
- flushDetectRange  in  1  selective flush request this cycle
- flushAll  in  1  with flushDetectRange, kill every valid entry
- flushHeadPtr  in  AL_PTR_WIDTH  range start, inclusive
- flushTailPtr  in  AL_PTR_WIDTH  range end, exclusive
- outValid  out  LANES  valid of stage DEPTH-1
- outPayload  out  LANES*PAYLOAD_WIDTH  payload of stage DEPTH-1
- outAlPtr  out  LANES*AL_PTR_WIDTH  pointer of stage DEPTH-1
- occupancy  out  $clog2(LANES*DEPTH+1)  popcount of all stage valid bits
- flushedCount  out  $clog2(LANES*(DEPTH+1)+1)  number of valid entries killed by flush this cycle

Behaviour:
- **Reset.** Async, active-low. All valid bits are 0; payload and pointer registers are 0. outValid=0, outPayload=0, outAlPtr=0, occupancy=0, flushedCount=0.
- **Range match** for pointer p, with F = flushDetectRange, A = flushAll, h = head, t = tail:
  - F=0: no match.
  - A=1: match.
  - t>h: match iff h≤p<t.
  - t<h: match iff p≥h or p<t.
  - t==h and A=0: empty range, no match.
- **Priority per cycle:** reset > clear > (stall | advance), with flush applied inside stall and advance.
- **clear=1:** all stage valid bits become 0; payload and pointer regs are don't-care (hold); flushedCount=0. clear overrides stall and flush.
- **stall=1, clear=0:**
  - Every stage holds its payload and pointer.
  - A stage valid bit becomes 0 if the entry is valid and matches the flush range.
  - Inputs are ignored (dropped). Upstream must not present new ops while stalled.
- **stall=0, clear=0:**
  - Stage 0 lane i ← input lane i.
  - Stage k lane i ← stage k-1 lane i.
  - The output-stage contents are consumed.
  - The written valid = source valid AND NOT match(source pointer).
  - Payload and pointer are copied regardless of valid.
- **Latency and ordering:** latency is exactly DEPTH cycles with no stall; lanes never cross.
- **flushedCount** is combinational from current state and inputs.
  - stall=0: counts matching valid entries in stages 0..DEPTH-2 plus matching valid inputs.
  - stall=1: counts matching valid entries in all stages.
  - In both cases, the output-stage entry being consumed is not counted, because it has already left.
- **occupancy** is a popcount of registered valid bits only.
- **Reset mid-operation:** all valids drop immediately (async); the first post-reset edge behaves as a normal cycle.
- **Edge cases:** DEPTH=1 and LANES=1 must synthesise. Pointer arithmetic is pure comparison (no add), so wrap needs no modulo logic.

Test Plan:
- **Fill and drain.** LANES=2, DEPTH=3. Inputs valid {1,1} with payloads 0xA0/0xA1 in cycle 0, then idle → outValid=2'b11, payload 0xA0/0xA1 at cycle 3; occupancy=2 during cycles 1-3; outValid=0 at cycle 4.
- **Stall hold.** Entry with pointer 5 in stage 1, stall for 4 cycles → outputs and occupancy unchanged during the stall; entry exits 2 cycles after stall release.
- **Non-wrapped flush.** Stages hold pointers 3, 7, 12; head=4, tail=10, detect=1, stall=0 → only the ptr-7 entry is killed; flushedCount=1; ptr 3 and ptr 12 continue.
- **Wrapped flush.** Pointers 62, 1, 30 (AL_PTR_WIDTH=6); head=60, tail=2 → ptr 62 and ptr 1 killed, ptr 30 kept; flushedCount=2. Then head=tail=5 with flushAll=0 → no kill.
- **Priority.** flushAll=1 together with stall=1 → all valid entries invalidated, flushedCount equals occupancy. clear=1 together with stall=1 → occupancy=0 next cycle, flushedCount=0.
- **Async reset.** Assert rst=0 mid-stream between clock edges → outValid=0 and occupancy=0 immediately. Release rst, then inject input → appears after DEPTH cycles.
